// File: rtl/conv_window_gen.sv
// conv_window_gen: K x K sliding-window generator with stride over an HWC AXI-Stream image
// Ports: i_aclk/i_aresetn clock and async active-low reset; i_tvalid/o_tready/i_tdata input
// element stream; o_tvalid/i_tready/o_tdata output window (element (ky,kx) at
// [(ky*KERNEL+kx)*WORD_WIDTH +: WORD_WIDTH]). Define CONV_WINDOW_TLAST_EN to add o_tlast,
// which marks the last window of each frame.
module conv_window_gen #(
  parameter int IN_HEIGHT  = 4,
  parameter int IN_WIDTH   = 4,
  parameter int IN_CHANNEL = 2,
  parameter int WORD_WIDTH = 8,
  parameter int KERNEL     = 3,
  parameter int STRIDE     = 1
) (
  input  logic                                 i_aclk,
  input  logic                                 i_aresetn,
  input  logic                                 i_tvalid,
  output logic                                 o_tready,
  input  logic [WORD_WIDTH-1:0]                i_tdata,
  input  logic                                 i_tready,
  output logic                                 o_tvalid,
  output logic [KERNEL*KERNEL*WORD_WIDTH-1:0]  o_tdata
`ifdef CONV_WINDOW_TLAST_EN
  ,
  output logic                                 o_tlast
`endif
);
  localparam int YW = $clog2(IN_HEIGHT);
  localparam int XW = $clog2(IN_WIDTH);
  localparam int CW = IN_CHANNEL > 1 ? $clog2(IN_CHANNEL) : 1;
  localparam int AW = $clog2(IN_WIDTH * IN_CHANNEL);
  localparam int WW = KERNEL * KERNEL * WORD_WIDTH;
  logic [YW-1:0] r;
  logic [XW-1:0] c;
  logic [CW-1:0] ch;
  logic [AW-1:0] a;
  logic ch_end, c_end, r_end, acc, emit;
  // lb[j] holds row r-1-j for every (column, channel) slot; win keeps one window per channel
  logic [WORD_WIDTH-1:0] lb [KERNEL-1][2**AW];
  logic [WW-1:0] win [2**CW];
  logic [WW-1:0] wn;
  assign ch_end   = ch == CW'(IN_CHANNEL - 1);
  assign c_end    = c == XW'(IN_WIDTH - 1);
  assign r_end    = r == YW'(IN_HEIGHT - 1);
  assign o_tready = !o_tvalid || i_tready;
  assign acc      = i_tvalid && o_tready;
  assign emit     = (32'(r) >= KERNEL - 1) && (32'(c) >= KERNEL - 1) &&
                    ((32'(r) - (KERNEL - 1)) % STRIDE == 0) &&
                    ((32'(c) - (KERNEL - 1)) % STRIDE == 0);
  // Next window for the current channel: shift left one column, new right column from the
  // row buffers (older rows on top) and the incoming word at the bottom.
  for (genvar y = 0; y < KERNEL; y++) begin : g_y
    for (genvar x = 0; x < KERNEL; x++) begin : g_x
      if (x < KERNEL - 1) begin : g_shift
        assign wn[(y*KERNEL+x)*WORD_WIDTH +: WORD_WIDTH] = win[ch][(y*KERNEL+x+1)*WORD_WIDTH +: WORD_WIDTH];
      end else if (y == KERNEL - 1) begin : g_new
        assign wn[(y*KERNEL+x)*WORD_WIDTH +: WORD_WIDTH] = i_tdata;
      end else begin : g_buf
        assign wn[(y*KERNEL+x)*WORD_WIDTH +: WORD_WIDTH] = lb[KERNEL-2-y][a];
      end
    end
  end
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r  <= '0;
      c  <= '0;
      ch <= '0;
      a  <= '0;
    end else if (acc) begin
      ch <= ch_end ? '0 : ch + 1'b1;
      a  <= (ch_end && c_end) ? '0 : a + 1'b1;
      if (ch_end) c <= c_end ? '0 : c + 1'b1;
      if (ch_end && c_end) r <= r_end ? '0 : r + 1'b1;
    end
  end
  always_ff @(posedge i_aclk) begin
    if (acc) begin
      lb[0][a] <= i_tdata;
      for (int j = 1; j < KERNEL - 1; j++) lb[j][a] <= lb[j-1][a];
      win[ch] <= wn;
    end
  end
`ifdef CONV_WINDOW_TLAST_EN
  localparam int LR = KERNEL - 1 + ((IN_HEIGHT - KERNEL) / STRIDE) * STRIDE;
  localparam int LC = KERNEL - 1 + ((IN_WIDTH - KERNEL) / STRIDE) * STRIDE;
  logic is_last;
  assign is_last = ch_end && (32'(r) == LR) && (32'(c) == LC);
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) o_tlast <= 1'b0;
    else if (acc && emit) o_tlast <= is_last;
  end
`endif
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      o_tvalid <= 1'b0;
      o_tdata  <= '0;
    end else if (acc && emit) begin
      o_tvalid <= 1'b1;
      o_tdata  <= wn;
    end else if (i_tready) begin
      o_tvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: randomized and directed checks of conv_window_gen against a window model
module tb_conv_window_gen;
  logic clk = 0, rst_n = 0, tvalid = 0, tready = 1, done = 0;
  logic [7:0] tdata = 0;
  int sel = 0, n_cmp = 0, n_err = 0, acc = 0;
  logic a_iv, a_or, a_ir, a_ov, b_iv, b_or, b_ir, b_ov, m_ov, m_or, m_ol;
  logic [71:0] a_od, b_od, m_od;
  logic [7:0] stim [0:127];
  logic [71:0] exp_q[$], got_q[$];
  int exp_idx[$], got_idx[$];
  logic exp_last[$], got_last[$];
  always #5 clk = ~clk;
  assign a_iv = sel == 0 && tvalid;
  assign b_iv = sel == 1 && tvalid;
  assign a_ir = sel == 0 ? tready : 1'b1;
  assign b_ir = sel == 1 ? tready : 1'b1;
  assign m_ov = sel == 1 ? b_ov : a_ov;
  assign m_or = sel == 1 ? b_or : a_or;
  assign m_od = sel == 1 ? b_od : a_od;
`ifdef CONV_WINDOW_TLAST_EN
  logic a_ol, b_ol;
  assign m_ol = sel == 1 ? b_ol : a_ol;
`else
  assign m_ol = 1'b0;
`endif
  conv_window_gen ua (
    .i_aclk(clk), .i_aresetn(rst_n), .i_tvalid(a_iv), .o_tready(a_or), .i_tdata(tdata),
    .i_tready(a_ir), .o_tvalid(a_ov), .o_tdata(a_od)
`ifdef CONV_WINDOW_TLAST_EN
    , .o_tlast(a_ol)
`endif
  );
  conv_window_gen #(.IN_HEIGHT(5), .IN_WIDTH(5), .IN_CHANNEL(1), .STRIDE(2)) ub (
    .i_aclk(clk), .i_aresetn(rst_n), .i_tvalid(b_iv), .o_tready(b_or), .i_tdata(tdata),
    .i_tready(b_ir), .o_tvalid(b_ov), .o_tdata(b_od)
`ifdef CONV_WINDOW_TLAST_EN
    , .o_tlast(b_ol)
`endif
  );
  // Windows are captured when a handshake is about to happen; acc counts words already
  // accepted, so acc-1 is the word whose acceptance produced a window when i_tready stays 1.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_ov && tready) begin
        got_q.push_back(m_od);
        got_idx.push_back(acc - 1);
        got_last.push_back(m_ol);
      end
      if (tvalid && m_or) acc++;
    end
  end
  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic clear();
    exp_q.delete(); exp_idx.delete(); exp_last.delete();
    got_q.delete(); got_idx.delete(); got_last.delete();
    acc = 0;
  endtask
  task automatic model(input int h, input int w, input int cn, input int s, input int off);
    int oh = (h - 3) / s + 1;
    int ow = (w - 3) / s + 1;
    logic [71:0] v;
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++)
        for (int k = 0; k < cn; k++) begin
          for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++)
              v[(ky*3+kx)*8 +: 8] = stim[off + ((oy*s+ky)*w + ox*s+kx)*cn + k];
          exp_q.push_back(v);
          exp_idx.push_back(off + ((oy*s+2)*w + ox*s+2)*cn + k);
          exp_last.push_back(oy == oh-1 && ox == ow-1 && k == cn-1);
        end
  endtask
  task automatic send(input int off, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      bit ok = 0;
      int t = 0;
      while (gap > 0 && $urandom_range(99) < gap) begin
        tvalid = 0;
        @(posedge clk); #1;
      end
      tvalid = 1;
      tdata = stim[off + i];
      while (!ok && t < 200) begin
        @(negedge clk) ok = m_or;
        @(posedge clk); #1;
        t++;
      end
      if (!ok) check("accept_timeout", 0, 1);
    end
    tvalid = 0;
  endtask
  task automatic drain();
    int t = 0;
    tready = 1;
    while (m_ov && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_idle", m_ov, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask
  task automatic compare(input string tag, input bit use_idx);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_win%0d", tag, i), got_q[i], exp_q[i]);
      if (use_idx) check($sformatf("%s_at%0d", tag, i), got_idx[i], exp_idx[i]);
`ifdef CONV_WINDOW_TLAST_EN
      check($sformatf("%s_last%0d", tag, i), got_last[i], exp_last[i]);
`endif
    end
  endtask
  task automatic rand_bp();
    while (!done) begin
      tready = $urandom_range(99) < 60;
      @(posedge clk); #1;
    end
    tready = 1;
  endtask
  task automatic stall();
    logic [71:0] cap;
    int t = 0;
    tready = 0;
    while (t < 200) begin
      @(negedge clk);
      if (m_ov) break;
      t++;
    end
    check("stall_seen", m_ov, 1);
    cap = m_od;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_data", m_od, cap);
      check("stall_ready", m_or, 0);
    end
    @(posedge clk); #1;
    tready = 1;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ov", a_ov, 0);
    check("rst_od", a_od, 0);
    rst_n = 1;
    @(negedge clk);
    check("rst_ready", a_or, 1);
    check("rst_ov_after", a_ov, 0);
    @(posedge clk); #1;
    // free-running default frame, n = n
    for (int i = 0; i < 128; i++) stim[i] = 8'(i % 32);
    clear(); model(4, 4, 2, 1, 0); send(0, 32, 0); drain();
    compare("t1", 1);
    check("t1_first", got_q.size() > 0 ? got_q[0] : '1, 72'h14_12_10_0c_0a_08_04_02_00);
    check("t1_lastwin", got_q.size() > 0 ? got_q[got_q.size()-1] : '1, 72'h1f_1d_1b_17_15_13_0f_0d_0b);
    // stride 2 on 5x5x1
    sel = 1;
    clear(); model(5, 5, 1, 2, 0); send(0, 25, 0); drain();
    compare("t2", 1);
    check("t2_first_at", got_idx.size() > 0 ? got_idx[0] : -1, 12);
    sel = 0;
    // directed 5-cycle backpressure
    clear(); model(4, 4, 2, 1, 0);
    fork
      send(0, 32, 0);
      stall();
    join
    drain();
    compare("t3", 0);
    // two back-to-back frames, i_tvalid held high
    clear(); model(4, 4, 2, 1, 0); model(4, 4, 2, 1, 32); send(0, 64, 0); drain();
    compare("t4", 1);
    check("t4_f2_first", got_q.size() > 8 ? got_q[8] : '1, 72'h14_12_10_0c_0a_08_04_02_00);
    // random data, random input gaps and random backpressure over two frames
    for (int i = 0; i < 64; i++) stim[i] = 8'($urandom);
    clear(); model(4, 4, 2, 1, 0); model(4, 4, 2, 1, 32);
    done = 0;
    fork
      begin send(0, 64, 30); done = 1; end
      rand_bp();
    join
    drain();
    compare("t5", 0);
    // reset mid-frame, then a clean frame
    for (int i = 0; i < 128; i++) stim[i] = 8'(i % 32);
    clear(); send(0, 18, 0);
    rst_n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_rst_ov", a_ov, 0);
    end
    @(posedge clk); #1;
    rst_n = 1;
    clear(); model(4, 4, 2, 1, 0); send(0, 32, 0); drain();
    compare("t6", 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
Parametrised K×K sliding-window generator with configurable stride. It is the next-generation front end for the Conv2D pipeline, generalising the fixed 3×3 input stage. It accepts an AXI-Stream image in raster order with the channel index innermost (HWC). For every valid output position and channel it emits one complete K×K window, which the downstream MAC array consumes.

Parameters:
- IN_HEIGHT, 4, image rows; must be ≥ KERNEL.
- IN_WIDTH, 4, image columns; must be ≥ KERNEL.
- IN_CHANNEL, 2, channels per pixel; must be ≥ 1.
- WORD_WIDTH, 8, bits per element.
- KERNEL, 3, window side K; must be ≥ 2.
- STRIDE, 1, window step S in both dimensions; must be ≥ 1.

Ports:
- i_aclk  in  1  clock; all logic is on the rising edge.
- i_aresetn  in  1  asynchronous active-low reset.
- i_tvalid  in  1  input word valid.
- o_tready  out  1  block accepts an input word.
- i_tdata  in  WORD_WIDTH  input element.
- i_tready  in  1  downstream accepts a window.
- o_tvalid  out  1  window valid.
- o_tdata  out  KERNEL*KERNEL*WORD_WIDTH  window. Element (ky,kx) sits at bits [(ky*KERNEL+kx)*WORD_WIDTH +: WORD_WIDTH]; ky=0 is the top row and kx=0 the left column.

Behaviour:
- Input word index: ((r*IN_WIDTH)+c)*IN_CHANNEL+ch. Row counter r, column counter c and channel counter ch advance on every accepted word (i_tvalid && o_tready).
- Counter wrap: ch wraps into c, c wraps into r. After (IN_HEIGHT-1, IN_WIDTH-1, IN_CHANNEL-1) all counters return to 0, and the next word starts a new frame with no idle cycle.
- Storage:
  - K-1 row buffers, each IN_WIDTH*IN_CHANNEL words, circular by row.
  - A K×K shift window per channel.
  - Memory contents are not reset.
- Emit condition: an output window is due when the accepted word satisfies r ≥ K-1, c ≥ K-1, (r-(K-1)) mod S == 0 and (c-(K-1)) mod S == 0.
- Window contents: rows r-K+1..r and columns c-K+1..c of channel ch, from the current frame only.
- Output size per frame: OUT_H = (IN_HEIGHT-K)/S+1 and OUT_W = (IN_WIDTH-K)/S+1 (integer division). Windows per frame = OUT_H*OUT_W*IN_CHANNEL, in the same raster order with channel innermost.
- Latency: o_tvalid rises on the clock edge that accepts the completing word, so it is visible in the following cycle.
- Output register:
  - Single stage.
  - o_tdata is held stable while o_tvalid && !i_tready.
  - o_tvalid drops after a handshake unless a new window loads in the same cycle.
- Input ready: o_tready = !o_tvalid || i_tready (combinational).
  - Non-emitting words also stall under backpressure; this keeps ordering simple.
  - No input is dropped and no window is duplicated.
- Simultaneous events: output handshake and a new emitting input in the same cycle means the register reloads and o_tvalid stays 1. Full throughput is 1 word per cycle.
- Reset values:
  - o_tvalid=0 and o_tdata=0.
  - All counters are 0.
  - o_tready=1 in the first cycle after deassertion.
- Reset mid-frame: partial frame discarded and pending window dropped. The next accepted word is treated as (0,0,0). Stale buffer data is never emitted because emission requires K-1 rows refilled.
- No mode state machine. Control is the counter set plus an output-valid flag. Frame phase (filling rows < K-1 / streaming) is decoded from r.

Optional Feature:
- Macro: CONV_WINDOW_TLAST_EN.
- When defined: adds output port o_tlast (1 bit).
  - o_tlast is 1 with the last window of each frame, i.e. position (OUT_H-1, OUT_W-1, IN_CHANNEL-1), and 0 otherwise.
  - It is held stable with o_tdata and resets to 0.
- When undefined: the port does not exist and there is no related logic.

Test Plan:
- Defaults (4×4×2, K=3, S=1), input word n = n for n = 0..31:
  - The first window (ch0) appears the cycle after word 20 is accepted, with elements 0,2,4,8,10,12,16,18,20.
  - The ch1 window follows one cycle later: 1,3,5,9,11,13,17,19,21.
  - Exactly 8 windows per frame; the last window is ch1 at (1,1), elements 11,13,15,19,21,23,27,29,31.
- STRIDE=2, IN_HEIGHT=IN_WIDTH=5, IN_CHANNEL=1, input n = n for n = 0..24:
  - Exactly 4 windows, first at word 12: 0,1,2,5,6,7,10,11,12.
  - Later windows at words 14, 22, 24; none at words 13 or 23.
- Backpressure: hold i_tready=0 for 5 cycles while o_tvalid=1.
  - o_tdata is unchanged and o_tready=0 throughout.
  - After release, window order and contents match the free-running run and the total is still 8.
- Back-to-back frames with i_tvalid held at 1 for 64 words (two defaults-config frames):
  - 16 windows total.
  - Second-frame windows contain only second-frame values (first ch0 window = 0,2,4,… again).
- Reset asserted after word 17 of a frame, then a full new frame sent:
  - o_tvalid is 0 during reset, and no window is emitted until new word 20.
  - Output is identical to the first test case.
- With CONV_WINDOW_TLAST_EN defined, defaults config: o_tlast=1 only on the 8th window of each frame, and 0 on windows 1–7.
